// File: rtl/audio_dac_serializer_pkg.sv
// Shared constants and FSM state encoding for the audio DAC serializer.
package audio_dac_serializer_pkg;

  localparam int AUDIO_DATA_WIDTH = 32;
  localparam int AUDIO_FIFO_DEPTH = 128;

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_LEFT       = 2'd1,
    ST_RIGHT      = 2'd2
  } dac_state_e;

endpackage

// File: rtl/audio_dac_serializer_fifo.sv
// Synchronous first-word-fall-through FIFO holding {left,right} sample pairs.
module audio_out_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 128,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] used,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] used_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Never write past full or read past empty, even if the caller asks.
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Pointer and fill-count bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      used_r   <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   used_r <= used_r + CNT_W'(1);
        2'b01:   used_r <= used_r - CNT_W'(1);
        default: used_r <= used_r;
      endcase
    end
  end

  // Storage array, no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

  assign dout  = mem_r[rd_ptr_r];
  assign used  = used_r;
  assign empty = (used_r == {CNT_W{1'b0}});
  assign full  = (used_r == CNT_W'(DEPTH));

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S transmit serializer: buffers stereo pairs and shifts them out on AUD_DACDAT
// following codec-mastered BCLK/LRCK.
module audio_dac_serializer
  import audio_dac_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = AUDIO_DATA_WIDTH,
  parameter int FIFO_DEPTH = AUDIO_FIFO_DEPTH,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  clear_audio_out_memory,
  input  logic [DATA_WIDTH-1:0] left_channel_audio_out,
  input  logic [DATA_WIDTH-1:0] right_channel_audio_out,
  input  logic                  write_audio_out,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DACLRCK,
  output logic                  audio_out_allowed,
  output logic [CNT_W-1:0]      fifo_used,
  output logic                  underflow,
  output logic                  AUD_DACDAT
);

  localparam int BC_W = $clog2(DATA_WIDTH + 1);

  logic bclk_meta_r, bclk_sync_r, bclk_prev_r;
  logic lr_meta_r, lr_sync_r, lr_prev_r;
  logic bclk_fall_s, lr_fall_s, lr_rise_s;

  logic                    push_s, pop_s, fifo_clear_s;
  logic [2*DATA_WIDTH-1:0] fifo_dout_s;
  logic [CNT_W-1:0]        fifo_used_s;
  logic [CNT_W-1:0]        next_used_s;
  logic                    fifo_empty_s, fifo_full_s;
  logic                    allowed_r;

  dac_state_e              state_r;
  logic [DATA_WIDTH-1:0]   shift_r;
  logic [DATA_WIDTH-1:0]   right_hold_r;
  logic [BC_W-1:0]         bit_cnt_r;
  logic                    dacdat_r;
  logic                    underflow_r;

  // Two-flop synchronizers for the codec clocks plus edge history; LRCK history
  // only advances on BCLK falls so frame edges line up with bit boundaries.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bclk_meta_r <= 1'b0;
      bclk_sync_r <= 1'b0;
      bclk_prev_r <= 1'b0;
      lr_meta_r   <= 1'b0;
      lr_sync_r   <= 1'b0;
      lr_prev_r   <= 1'b0;
    end else begin
      bclk_meta_r <= AUD_BCLK;
      bclk_sync_r <= bclk_meta_r;
      bclk_prev_r <= bclk_sync_r;
      lr_meta_r   <= AUD_DACLRCK;
      lr_sync_r   <= lr_meta_r;
      if (bclk_fall_s) lr_prev_r <= lr_sync_r;
      else             lr_prev_r <= lr_prev_r;
    end
  end

  assign bclk_fall_s = bclk_prev_r & ~bclk_sync_r;
  assign lr_fall_s   = bclk_fall_s & lr_prev_r & ~lr_sync_r;
  assign lr_rise_s   = bclk_fall_s & ~lr_prev_r & lr_sync_r;

  assign fifo_clear_s = reset | clear_audio_out_memory;
  assign push_s       = write_audio_out & allowed_r & ~fifo_full_s;
  assign pop_s        = lr_fall_s & ~fifo_empty_s;

  audio_out_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (CLOCK_50),
    .push  (push_s),
    .pop   (pop_s),
    .clear (fifo_clear_s),
    .din   ({left_channel_audio_out, right_channel_audio_out}),
    .dout  (fifo_dout_s),
    .used  (fifo_used_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  // Fill count after this edge, used to register the write-permission flag.
  always_comb begin
    next_used_s = fifo_used_s;
    if (fifo_clear_s) begin
      next_used_s = {CNT_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   next_used_s = fifo_used_s + CNT_W'(1);
        2'b01:   next_used_s = fifo_used_s - CNT_W'(1);
        default: next_used_s = fifo_used_s;
      endcase
    end
  end

  // Registered write permission so an accepted write can never overflow.
  always_ff @(posedge CLOCK_50) begin
    if (reset) allowed_r <= 1'b0;
    else       allowed_r <= (next_used_s < CNT_W'(FIFO_DEPTH));
  end

  // Frame FSM and shift register: load on LRCK edges, shift one bit per later BCLK fall.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r      <= ST_WAIT_FRAME;
      shift_r      <= {DATA_WIDTH{1'b0}};
      right_hold_r <= {DATA_WIDTH{1'b0}};
      bit_cnt_r    <= {BC_W{1'b0}};
      dacdat_r     <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      underflow_r <= 1'b0;
      if (lr_fall_s) begin
        if (fifo_empty_s) begin
          shift_r      <= {DATA_WIDTH{1'b0}};
          right_hold_r <= {DATA_WIDTH{1'b0}};
          underflow_r  <= 1'b1;
        end else begin
          shift_r      <= fifo_dout_s[2*DATA_WIDTH-1 -: DATA_WIDTH];
          right_hold_r <= fifo_dout_s[DATA_WIDTH-1:0];
        end
        bit_cnt_r <= BC_W'(DATA_WIDTH);
        state_r   <= ST_LEFT;
      end else if (bclk_fall_s) begin
        if (state_r == ST_LEFT && lr_rise_s) begin
          shift_r   <= right_hold_r;
          bit_cnt_r <= BC_W'(DATA_WIDTH);
          state_r   <= ST_RIGHT;
        end else if (state_r == ST_LEFT || state_r == ST_RIGHT) begin
          if (bit_cnt_r != {BC_W{1'b0}}) begin
            dacdat_r  <= shift_r[DATA_WIDTH-1];
            shift_r   <= {shift_r[DATA_WIDTH-2:0], 1'b0};
            bit_cnt_r <= bit_cnt_r - BC_W'(1);
          end else begin
            dacdat_r <= 1'b0;
          end
        end else begin
          dacdat_r <= 1'b0;
          state_r  <= ST_WAIT_FRAME;
        end
      end
    end
  end

  assign audio_out_allowed = allowed_r;
  assign fifo_used         = fifo_used_s;
  assign underflow         = underflow_r;
  assign AUD_DACDAT        = dacdat_r;

endmodule
